fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 14 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/fb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_fb_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared swap-FSM state type and default geometry for the frame-buffer arbiter.
package fb_pkg;

    localparam int unsigned DataWidth = 16;
    localparam int unsigned Depth     = 768;
    localparam int unsigned AddrWidth = 10;
    localparam int unsigned FifoDepth = 4;

    typedef enum logic [0:0] {
        StIdle,
        StPending
    } swap_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; Depth must be a power of two so the
// pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned Width = 26,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Double-buffered frame-store arbiter: display reads own the single RAM port,
// sensor writes are buffered and drained into the back bank, banks swap on vsync.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned p_data_width = DataWidth,
    parameter int unsigned p_depth      = Depth,
    parameter int unsigned p_addr_width = AddrWidth,
    parameter int unsigned p_fifo_depth = FifoDepth
) (
    input  logic                    i_clk_pixel,
    input  logic                    i_rst_n,
    input  logic                    i_vsync,
    input  logic                    i_rd_req,
    input  logic [p_addr_width-1:0] i_rd_addr,
    output logic                    o_rd_valid,
    output logic [p_data_width-1:0] o_rd_data,
    input  logic                    i_wr_valid,
    output logic                    o_wr_ready,
    input  logic [p_addr_width-1:0] i_wr_addr,
    input  logic [p_data_width-1:0] i_wr_data,
    input  logic                    i_frame_done,
    output logic                    o_mem_en,
    output logic                    o_mem_we,
    output logic [p_addr_width:0]   o_mem_addr,
    output logic [p_data_width-1:0] o_mem_wdata,
    input  logic [p_data_width-1:0] i_mem_rdata,
    output logic                    o_bank,
    output logic                    o_swap,
    output logic                    o_err
);

    localparam int unsigned          FifoWidth = p_addr_width + p_data_width;
    localparam logic [p_addr_width:0] DepthLim = (p_addr_width + 1)'(p_depth);

    swap_state_e state_q, state_d;
    logic        vsync_q, vsync_rise, swap_fire;
    logic        bank_q, swap_q, err_q, err_d;

    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FifoWidth-1:0]    fifo_rdata;
    logic [p_addr_width-1:0] head_addr;
    logic [p_data_width-1:0] head_data;
    logic                    rd_oob, wr_oob, wr_accept;

    logic                    mem_en_d, mem_en_q, mem_we_d, mem_we_q;
    logic [p_addr_width:0]   mem_addr_d, mem_addr_q;
    logic [p_data_width-1:0] mem_wdata_d, mem_wdata_q;

    logic                    rd_p1_q, rd_p2_q, oob_p1_q, oob_p2_q, rd_valid_q;
    logic [p_data_width-1:0] rd_data_q;

    assign vsync_rise = i_vsync & ~vsync_q;
    assign rd_oob     = ({1'b0, i_rd_addr} >= DepthLim);
    assign wr_oob     = ({1'b0, i_wr_addr} >= DepthLim);
    assign o_wr_ready = ~fifo_full & (state_q == StIdle);
    assign wr_accept  = i_wr_valid & o_wr_ready;
    // Out-of-range writes complete the handshake but never enter the buffer.
    assign fifo_push  = wr_accept & ~wr_oob;
    assign fifo_pop   = ~i_rd_req & ~fifo_empty;
    assign head_addr  = fifo_rdata[FifoWidth-1 -: p_addr_width];
    assign head_data  = fifo_rdata[p_data_width-1:0];
    assign err_d      = err_q | (i_rd_req & rd_oob) | (wr_accept & wr_oob);

    sync_fifo #(
        .Width (FifoWidth),
        .Depth (p_fifo_depth)
    ) u_wr_fifo (
        .clk_i   (i_clk_pixel),
        .rst_ni  (i_rst_n),
        .push_i  (fifo_push),
        .wdata_i ({i_wr_addr, i_wr_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Swap FSM: state register.
    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Swap FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (i_frame_done) state_d = StPending;
            StPending: if (vsync_rise && fifo_empty) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Swap FSM: outputs. A vsync edge with writes still buffered is skipped.
    always_comb begin
        swap_fire = (state_q == StPending) & vsync_rise & fifo_empty;
    end

    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vsync_q <= 1'b0;
            bank_q  <= 1'b0;
            swap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            vsync_q <= i_vsync;
            bank_q  <= bank_q ^ swap_fire;
            swap_q  <= swap_fire;
            err_q   <= err_d;
        end
    end

    // RAM command: reads win; the FIFO head drains only on read-idle cycles.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (i_rd_req) begin
            if (!rd_oob) begin
                mem_en_d   = 1'b1;
                mem_addr_d = {bank_q, i_rd_addr};
            end
        end else if (!fifo_empty) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {~bank_q, head_addr};
            mem_wdata_d = head_data;
        end
    end

    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_p1_q     <= 1'b0;
            rd_p2_q     <= 1'b0;
            oob_p1_q    <= 1'b0;
            oob_p2_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_p1_q     <= i_rd_req;
            oob_p1_q    <= i_rd_req & rd_oob;
            rd_p2_q     <= rd_p1_q;
            oob_p2_q    <= oob_p1_q;
            rd_valid_q  <= rd_p2_q;
            if (rd_p2_q) begin
                rd_data_q <= oob_p2_q ? '0 : i_mem_rdata;
            end
        end
    end

    assign o_mem_en    = mem_en_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_data   = rd_data_q;
    assign o_bank      = bank_q;
    assign o_swap      = swap_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter: stimulus pushes expected reads/writes, a
// negedge monitor pops and compares whatever the DUT presents.
module tb_fb_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } rd_exp_t;

    typedef struct {
        logic [AW:0]   addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_vsync = 1'b0;
    logic          i_rd_req = 1'b0;
    logic [AW-1:0] i_rd_addr = '0;
    logic          o_rd_valid;
    logic [DW-1:0] o_rd_data;
    logic          i_wr_valid = 1'b0;
    logic          o_wr_ready;
    logic [AW-1:0] i_wr_addr = '0;
    logic [DW-1:0] i_wr_data = '0;
    logic          i_frame_done = 1'b0;
    logic          o_mem_en, o_mem_we;
    logic [AW:0]   o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata = '0;
    logic          o_bank, o_swap, o_err;

    int      cyc = 0;
    int      pass_cnt = 0;
    int      total_cnt = 0;
    int      wr_seen = 0;
    int      swap_cnt = 0;
    logic    exp_bank = 1'b0;
    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    rd_exp_t mon_re;
    wr_exp_t mon_we;

    fb_arbiter dut (
        .i_clk_pixel  (clk),
        .i_rst_n      (i_rst_n),
        .i_vsync      (i_vsync),
        .i_rd_req     (i_rd_req),
        .i_rd_addr    (i_rd_addr),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .i_wr_valid   (i_wr_valid),
        .o_wr_ready   (o_wr_ready),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .i_frame_done (i_frame_done),
        .o_mem_en     (o_mem_en),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .o_bank       (o_bank),
        .o_swap       (o_swap),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM contents: bank 0 holds its address, bank 1 holds 0x4000 + address.
    function automatic logic [DW-1:0] ram_word(input logic [AW:0] a);
        logic [DW-1:0] lo;
        lo = {6'b0, a[AW-1:0]};
        return a[AW] ? (16'h4000 + lo) : lo;
    endfunction

    always @(posedge clk) begin
        if (o_mem_en && !o_mem_we) i_mem_rdata <= ram_word(o_mem_addr);
    end

    function automatic logic [DW-1:0] exp_rd(input int a);
        logic [AW:0] full;
        if (a >= 768) return '0;
        full = {exp_bank, a[AW-1:0]};
        return ram_word(full);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (i_rst_n) begin
            if (o_rd_valid) begin
                if (rd_q.size() == 0) begin
                    check("rd_spurious_valid", o_rd_valid, 0);
                end else begin
                    mon_re = rd_q.pop_front();
                    check("rd_data", o_rd_data, mon_re.data);
                    check("rd_latency", cyc, mon_re.cyc);
                end
            end
            if (o_mem_en && o_mem_we) begin
                wr_seen++;
                if (wr_q.size() == 0) begin
                    check("wr_spurious", o_mem_we, 0);
                end else begin
                    mon_we = wr_q.pop_front();
                    check("wr_addr", o_mem_addr, mon_we.addr);
                    check("wr_data", o_mem_wdata, mon_we.data);
                end
            end
            if (o_swap) swap_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_drive(input logic rd, input int ra, input logic wv, input int wa,
                             input logic [DW-1:0] wd, input logic fd);
        i_rd_req     = rd;
        i_rd_addr    = ra[AW-1:0];
        i_wr_valid   = wv;
        i_wr_addr    = wa[AW-1:0];
        i_wr_data    = wd;
        i_frame_done = fd;
        if (rd) rd_q.push_back('{data: exp_rd(ra), cyc: cyc + 3});
        if (wv && o_wr_ready && wa < 768) wr_q.push_back('{addr: {~exp_bank, wa[AW-1:0]}, data: wd});
        step();
    endtask

    task automatic idle();
        cyc_drive(1'b0, 0, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic drain(input string name);
        idle();
        for (int i = 0; i < 60; i++) begin
            if (rd_q.size() == 0 && wr_q.size() == 0) break;
            step();
        end
        check({name, "_rd_drained"}, rd_q.size(), 0);
        check({name, "_wr_drained"}, wr_q.size(), 0);
        step();
        step();
    endtask

    task automatic reset_dut();
        i_rd_req = 0; i_wr_valid = 0; i_frame_done = 0; i_vsync = 0;
        i_rd_addr = '0; i_wr_addr = '0; i_wr_data = '0;
        i_rst_n = 1'b0;
        #1;
        check("rst_bank", o_bank, 0);
        check("rst_swap", o_swap, 0);
        check("rst_err", o_err, 0);
        check("rst_rd_valid", o_rd_valid, 0);
        check("rst_rd_data", o_rd_data, 0);
        check("rst_mem_en", o_mem_en, 0);
        check("rst_mem_we", o_mem_we, 0);
        rd_q.delete();
        wr_q.delete();
        exp_bank = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
        #1;
        check("rst_wr_ready", o_wr_ready, 1);
        step();
    endtask

    int w0, s0;

    initial begin
        step();
        reset_dut();

        // Continuous reads across the whole bank.
        for (int a = 0; a < 768; a++) cyc_drive(1'b1, a, 1'b0, 0, '0, 1'b0);
        drain("rdonly");

        // Four writes queue behind a read burst and drain in order once reads stop.
        w0 = wr_seen;
        for (int i = 0; i < 4; i++) cyc_drive(1'b1, 100 + i, 1'b1, 10 + i, 16'hC000 + 16'(i), 1'b0);
        check("wr_ready_full", o_wr_ready, 0);
        for (int i = 0; i < 6; i++) cyc_drive(1'b1, 104 + i, 1'b1, 14, 16'hCCCC, 1'b0);
        check("no_wr_during_reads", wr_seen - w0, 0);
        drain("contention");
        check("contention_wr_count", wr_seen - w0, 4);
        check("wr_ready_after_drain", o_wr_ready, 1);

        // Out-of-range read returns zero with normal latency and sets the error.
        check("err_clear_before", o_err, 0);
        cyc_drive(1'b1, 800, 1'b0, 0, '0, 1'b0);
        drain("oob_rd");
        check("err_after_oob_rd", o_err, 1);

        // Out-of-range write is accepted but never reaches the RAM.
        reset_dut();
        w0 = wr_seen;
        check("oob_wr_ready", o_wr_ready, 1);
        cyc_drive(1'b0, 0, 1'b1, 768, 16'hBEEF, 1'b0);
        drain("oob_wr");
        check("oob_wr_no_write", wr_seen - w0, 0);
        check("err_after_oob_wr", o_err, 1);

        // Plain swap with an empty buffer.
        reset_dut();
        s0 = swap_cnt;
        cyc_drive(1'b0, 0, 1'b0, 0, '0, 1'b1);
        check("pending_blocks_wr", o_wr_ready, 0);
        i_vsync = 1'b1;
        idle();
        check("swap_pulse", o_swap, 1);
        check("swap_bank", o_bank, 1);
        exp_bank = 1'b1;
        idle();
        check("swap_pulse_end", o_swap, 0);
        idle();
        i_vsync = 1'b0;
        idle();
        check("swap_once", swap_cnt - s0, 1);
        check("swap_idle_ready", o_wr_ready, 1);
        cyc_drive(1'b1, 5, 1'b0, 0, '0, 1'b0);
        cyc_drive(1'b1, 6, 1'b0, 0, '0, 1'b0);
        drain("bank1_rd");

        // Swap deferred while writes are still buffered.
        reset_dut();
        s0 = swap_cnt;
        cyc_drive(1'b1, 20, 1'b1, 30, 16'hD000, 1'b0);
        cyc_drive(1'b1, 21, 1'b1, 31, 16'hD001, 1'b0);
        cyc_drive(1'b1, 22, 1'b0, 0, '0, 1'b1);
        i_vsync = 1'b1;
        cyc_drive(1'b1, 23, 1'b0, 0, '0, 1'b0);
        cyc_drive(1'b1, 24, 1'b0, 0, '0, 1'b1);
        cyc_drive(1'b1, 25, 1'b0, 0, '0, 1'b0);
        check("defer_no_swap", swap_cnt - s0, 0);
        check("defer_bank", o_bank, 0);
        i_vsync = 1'b0;
        drain("defer");
        check("defer_still_pending", o_wr_ready, 0);
        check("defer_no_swap_drained", swap_cnt - s0, 0);
        i_vsync = 1'b1;
        idle();
        check("defer_swap_pulse", o_swap, 1);
        check("defer_swap_bank", o_bank, 1);
        exp_bank = 1'b1;
        i_vsync = 1'b0;
        idle();
        idle();
        check("defer_swap_once", swap_cnt - s0, 1);
        check("defer_idle_ready", o_wr_ready, 1);

        // frame_done on the vsync edge arms the swap for the following edge only.
        s0 = swap_cnt;
        i_vsync = 1'b1;
        cyc_drive(1'b0, 0, 1'b0, 0, '0, 1'b1);
        check("coinc_no_swap", o_swap, 0);
        check("coinc_pending", o_wr_ready, 0);
        idle();
        idle();
        check("coinc_bank_kept", o_bank, 1);
        check("coinc_count", swap_cnt - s0, 0);
        i_vsync = 1'b0;
        idle();
        i_vsync = 1'b1;
        idle();
        check("coinc_swap_pulse", o_swap, 1);
        check("coinc_swap_bank", o_bank, 0);
        exp_bank = 1'b0;
        i_vsync = 1'b0;
        idle();

        // Reset with three buffered writes and a pending swap.
        cyc_drive(1'b1, 40, 1'b1, 50, 16'hE000, 1'b0);
        cyc_drive(1'b1, 41, 1'b1, 51, 16'hE001, 1'b0);
        cyc_drive(1'b1, 42, 1'b1, 52, 16'hE002, 1'b0);
        cyc_drive(1'b1, 43, 1'b0, 0, '0, 1'b1);
        cyc_drive(1'b1, 44, 1'b0, 0, '0, 1'b0);
        check("pre_rst_pending", o_wr_ready, 0);
        w0 = wr_seen;
        reset_dut();
        for (int i = 0; i < 10; i++) idle();
        check("post_rst_no_writes", wr_seen - w0, 0);
        check("post_rst_bank", o_bank, 0);
        check("post_rst_ready", o_wr_ready, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
